// File: rtl/gb_pixel_writer_pkg.sv
// Shared video definitions: PPU mode encoding, writer states and LCD geometry.
package gb_video_pkg;

   typedef enum logic [1:0] {
      H_BLANK = 2'd0,
      V_BLANK = 2'd1,
      SCAN    = 2'd2,
      DRAW    = 2'd3
   } PPU_STATES_t;

   typedef enum logic [1:0] {
      WR_IDLE   = 2'd0,
      WR_ACTIVE = 2'd1,
      WR_FLUSH  = 2'd2
   } wr_state_t;

   localparam int unsigned LINE_PX        = 160;
   localparam int unsigned LINES          = 144;
   localparam int unsigned BYTES_PER_LINE = LINE_PX / 4;
   localparam int unsigned BANK_BYTES     = LINES * BYTES_PER_LINE;

endpackage

// File: rtl/gb_pixel_writer_if.sv
// Framebuffer write port: ready/valid byte writes into the 2bpp frame RAM.
interface gb_pixel_writer_if;
   logic [13:0] fb_addr;
   logic [7:0]  fb_wdata;
   logic        fb_we;
   logic        fb_ready;

   modport master (output fb_addr, output fb_wdata, output fb_we, input fb_ready);
   modport slave  (input fb_addr, input fb_wdata, input fb_we, output fb_ready);
endinterface

// File: rtl/gb_pixel_writer_fifo.sv
// Small synchronous FIFO of packed {address, byte} words headed for the frame RAM.
module gb_px_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 22
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             wr_en;
   logic             rd_en;

   // A push into a full FIFO is only taken when the head leaves in the same cycle.
   always_comb begin
      empty = (wr_ptr == rd_ptr);
      full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
      rd_en = pop && !empty;
      wr_en = push && (!full || rd_en);
      rdata = mem[rd_ptr[AW-1:0]];
   end

   // Storage and pointers; reset clears contents so the head reads as zero.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      end
   end
endmodule

// File: rtl/gb_pixel_writer.sv
// Palette-maps the PPU pixel stream, packs 4 shades per byte and writes them
// into a double-buffered framebuffer, swapping banks at each completed frame.
module gb_pixel_writer
   import gb_video_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        px_in,
   input  logic              px_valid,
   input  logic [1:0]        ppu_mode,
   input  logic              lcd_en,
   input  logic [7:0]        bgp,
   gb_pixel_writer_if.master fb,
   output logic              disp_bank,
   output logic              frame_done,
   output logic              ovf,
   input  logic              ovf_clr
);
   localparam logic [1:0]  ST_IDLE      = 2'(WR_IDLE);
   localparam logic [1:0]  ST_ACTIVE    = 2'(WR_ACTIVE);
   localparam logic [1:0]  ST_FLUSH     = 2'(WR_FLUSH);
   localparam logic [7:0]  LINE_PX_C    = 8'(LINE_PX);
   localparam logic [7:0]  LAST_LINE_C  = 8'(LINES - 1);
   localparam logic [13:0] BANK_BYTES_C = 14'(BANK_BYTES);
   localparam logic [13:0] BPL_C        = 14'(BYTES_PER_LINE);
   localparam logic [1:0]  HBLANK_C     = 2'(H_BLANK);

   logic [1:0]  state;
   logic        wbank;
   logic [7:0]  x;
   logic [7:0]  y;
   logic [7:0]  pack;
   logic [1:0]  mode_q;
   logic [1:0]  shade;
   logic [7:0]  pack_nxt;
   logic [13:0] addr;
   logic        active;
   logic        line_end;
   logic        px_take;
   logic        push;
   logic [21:0] push_word;
   logic [21:0] head;
   logic        full;
   logic        empty;
   logic        pop;

   function automatic logic [1:0] pal_shade(input logic [7:0] pal, input logic [1:0] idx);
      case (idx)
         2'd0:    return pal[1:0];
         2'd1:    return pal[3:2];
         2'd2:    return pal[5:4];
         default: return pal[7:6];
      endcase
   endfunction

   // Pixel 0 of a group lands in the most significant slot.
   function automatic logic [7:0] place_shade(input logic [1:0] s, input logic [1:0] slot);
      case (slot)
         2'd0:    return {s, 6'b0};
         2'd1:    return {2'b0, s, 4'b0};
         2'd2:    return {4'b0, s, 2'b0};
         default: return {6'b0, s};
      endcase
   endfunction

   // Decode pixel acceptance, line ends and the word pushed toward the RAM.
   always_comb begin
      shade     = pal_shade(bgp, px_in);
      pack_nxt  = pack | place_shade(shade, x[1:0]);
      addr      = (wbank ? BANK_BYTES_C : 14'd0) + (14'(y) * BPL_C) + 14'(x[7:2]);
      active    = (state == ST_ACTIVE) && lcd_en;
      line_end  = active && (mode_q != HBLANK_C) && (ppu_mode == HBLANK_C);
      px_take   = active && !line_end && px_valid && (x < LINE_PX_C);
      push      = (px_take && (x[1:0] == 2'd3)) || (line_end && (x[1:0] != 2'd0));
      push_word = {addr, (px_take ? pack_nxt : pack)};
      pop       = fb.fb_we && fb.fb_ready;
   end

   gb_px_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(22)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .wdata (push_word),
      .pop   (pop),
      .rdata (head),
      .full  (full),
      .empty (empty)
   );

   assign fb.fb_we    = !empty;
   assign fb.fb_addr  = head[21:8];
   assign fb.fb_wdata = head[7:0];

   // Previous PPU mode, used to spot the transition into H_BLANK.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) mode_q <= HBLANK_C;
      else      mode_q <= ppu_mode;
   end

   // Writer FSM: position tracking, packing, end-of-frame bank swap.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= ST_IDLE;
         wbank      <= 1'b0;
         disp_bank  <= 1'b1;
         x          <= '0;
         y          <= '0;
         pack       <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (!lcd_en) begin
            state <= ST_IDLE;
            x     <= '0;
            y     <= '0;
            pack  <= '0;
         end else begin
            case (state)
               ST_IDLE: state <= ST_ACTIVE;
               ST_ACTIVE: begin
                  if (line_end) begin
                     x    <= '0;
                     pack <= '0;
                     if (x != 8'd0) begin
                        if (y == LAST_LINE_C) begin
                           y     <= '0;
                           state <= ST_FLUSH;
                        end else begin
                           y <= y + 8'd1;
                        end
                     end
                  end else if (px_take) begin
                     x    <= x + 8'd1;
                     pack <= (x[1:0] == 2'd3) ? 8'd0 : pack_nxt;
                  end
               end
               ST_FLUSH: begin
                  // Nothing is pushed here, so an empty FIFO means the frame is committed.
                  if (empty) begin
                     frame_done <= 1'b1;
                     wbank      <= ~wbank;
                     disp_bank  <= wbank;
                     state      <= ST_ACTIVE;
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

   // Sticky overflow: a byte lost to a full FIFO wins over a same-cycle clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                       ovf <= 1'b0;
      else if (push && full && !pop)  ovf <= 1'b1;
      else if (ovf_clr)               ovf <= 1'b0;
   end
endmodule

// File: tb/tb_gb_pixel_writer.sv
// Directed bench for gb_pixel_writer: packing, line/frame sequencing, handshake and overflow.
module tb_gb_pixel_writer;
   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] px_in;
   logic       px_valid;
   logic [1:0] ppu_mode;
   logic       lcd_en;
   logic [7:0] bgp;
   logic       disp_bank;
   logic       frame_done;
   logic       ovf;
   logic       ovf_clr;

   gb_pixel_writer_if fb ();

   gb_pixel_writer #(.FIFO_DEPTH(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .px_in      (px_in),
      .px_valid   (px_valid),
      .ppu_mode   (ppu_mode),
      .lcd_en     (lcd_en),
      .bgp        (bgp),
      .fb         (fb),
      .disp_bank  (disp_bank),
      .frame_done (frame_done),
      .ovf        (ovf),
      .ovf_clr    (ovf_clr)
   );

   always #5 clk = ~clk;

   int          n_assert = 0;
   int          n_fail   = 0;
   logic [13:0] wr_addr[$];
   logic [7:0]  wr_data[$];
   int          fd_cnt = 0;

   // Log every accepted write and every frame_done pulse, sampled mid-cycle.
   always @(negedge clk) begin
      if (rst && fb.fb_we && fb.fb_ready) begin
         wr_addr.push_back(fb.fb_addr);
         wr_data.push_back(fb.fb_wdata);
      end
      if (rst && frame_done) fd_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pix(input logic [1:0] p);
      px_in    = p;
      px_valid = 1'b1;
      tick();
      px_valid = 1'b0;
   endtask

   task automatic line_end();
      ppu_mode = 2'd0;
      tick();
      ppu_mode = 2'd3;
      tick();
   endtask

   task automatic full_line();
      for (int i = 0; i < 160; i++) pix(2'(i % 4));
      line_end();
   endtask

   int base;
   int fd0;
   int bad;

   initial begin
      rst = 1'b0; px_in = 2'd0; px_valid = 1'b0; ppu_mode = 2'd0;
      lcd_en = 1'b0; bgp = 8'hE4; ovf_clr = 1'b0; fb.fb_ready = 1'b1;
      tick(); tick();
      check("rst_we", fb.fb_we, 0);
      check("rst_addr", fb.fb_addr, 0);
      check("rst_wdata", fb.fb_wdata, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_ovf", ovf, 0);
      check("rst_disp_bank", disp_bank, 1);
      rst = 1'b1;
      tick();
      lcd_en = 1'b1; ppu_mode = 2'd3;
      tick();

      // First group under bgp E4, write one cycle after the 4th pixel
      pix(2'd0); pix(2'd1); pix(2'd2);
      check("we_before_4th", fb.fb_we, 0);
      pix(2'd3);
      check("we_latency", fb.fb_we, 1);
      check("first_addr", fb.fb_addr, 14'd0);
      check("first_data_e4", fb.fb_wdata, 8'h1B);
      tick();
      check("we_after_pop", fb.fb_we, 0);
      check("write_count_1", wr_addr.size(), 1);
      line_end();

      // bgp 1B, partial byte flush, next line address
      bgp = 8'h1B;
      base = wr_addr.size();
      pix(2'd0); pix(2'd1); pix(2'd2); pix(2'd3);
      check("line1_addr", fb.fb_addr, 14'd40);
      check("line1_data_1b", fb.fb_wdata, 8'hE4);
      pix(2'd3); pix(2'd3);
      line_end();
      pix(2'd0); pix(2'd0); pix(2'd0); pix(2'd0);
      tick();
      check("pad_count", wr_addr.size() - base, 3);
      check("pad_addr", wr_addr[base+1], 14'd41);
      check("pad_data", wr_data[base+1], 8'h00);
      check("line2_addr", wr_addr[base+2], 14'd80);
      check("line2_data", wr_data[base+2], 8'hFF);
      line_end();

      // 161 pixels: last one discarded
      base = wr_addr.size();
      for (int i = 0; i < 161; i++) pix(2'd1);
      tick(); tick();
      check("long_count", wr_addr.size() - base, 40);
      check("long_first", wr_addr[base], 14'd120);
      check("long_last", wr_addr[base+39], 14'd159);
      check("long_data", wr_data[base+39], 8'hAA);
      check("long_ovf", ovf, 0);
      line_end();
      line_end();
      pix(2'd0); pix(2'd0); pix(2'd0); pix(2'd0);
      tick();
      check("empty_line_y_held", wr_addr[wr_addr.size()-1], 14'd160);
      line_end();

      // Back-pressure and overflow on line 5
      fb.fb_ready = 1'b0;
      base = wr_addr.size();
      for (int i = 0; i < 40; i++) pix(2'd2);
      check("ovf_set", ovf, 1);
      check("stall_we", fb.fb_we, 1);
      check("stall_addr", fb.fb_addr, 14'd200);
      check("stall_data", fb.fb_wdata, 8'h55);
      check("stall_no_accept", wr_addr.size() - base, 0);
      ovf_clr = 1'b1;
      tick();
      check("ovf_clr", ovf, 0);
      pix(2'd2); pix(2'd2); pix(2'd2); pix(2'd2);
      check("ovf_set_beats_clr", ovf, 1);
      tick();
      ovf_clr = 1'b0;
      check("ovf_clr_again", ovf, 0);
      pix(2'd2); pix(2'd2); pix(2'd2);
      fb.fb_ready = 1'b1;
      pix(2'd2);
      check("full_push_pop_no_ovf", ovf, 0);
      for (int i = 0; i < 6; i++) tick();
      check("drain_count", wr_addr.size() - base, 5);
      check("drain_head", wr_addr[base], 14'd200);
      check("drain_4th", wr_addr[base+3], 14'd203);
      check("drain_new", wr_addr[base+4], 14'd211);
      line_end();

      // Reset with a write pending
      fb.fb_ready = 1'b0;
      pix(2'd0); pix(2'd0); pix(2'd0); pix(2'd0);
      check("pending_we", fb.fb_we, 1);
      #3 rst = 1'b0;
      #1;
      check("async_rst_we", fb.fb_we, 0);
      check("async_rst_addr", fb.fb_addr, 0);
      tick();
      rst = 1'b1;
      fb.fb_ready = 1'b1;
      tick();
      check("rst_fifo_lost", fb.fb_we, 0);

      // Full frame
      bgp = 8'hE4;
      base = wr_addr.size();
      fd0 = fd_cnt;
      for (int l = 0; l < 144; l++) full_line();
      for (int i = 0; i < 50 && fd_cnt == fd0; i++) tick();
      tick(); tick(); tick();
      check("frame_done_once", fd_cnt - fd0, 1);
      check("frame_done_low", frame_done, 0);
      check("frame_count", wr_addr.size() - base, 5760);
      bad = 0;
      for (int i = 0; i < 5760; i++)
         if (wr_addr[base+i] !== 14'(i) || wr_data[base+i] !== 8'h1B) bad++;
      check("frame_contents", bad, 0);
      check("disp_bank_swap", disp_bank, 0);

      // Second frame into bank 1, interrupted by lcd_en at y=70
      base = wr_addr.size();
      for (int l = 0; l < 70; l++) full_line();
      check("bank1_first", wr_addr[base], 14'd5760);
      check("bank1_count", wr_addr.size() - base, 2800);
      check("bank1_last", wr_addr[base+2799], 14'd8559);
      for (int i = 0; i < 8; i++) pix(2'(i % 4));
      lcd_en = 1'b0;
      tick(); tick(); tick();
      pix(2'd0); pix(2'd0); pix(2'd0); pix(2'd0);
      tick();
      check("idle_ignores_px", wr_addr.size() - base, 2802);
      check("lcd_off_no_frame_done", fd_cnt - fd0, 1);
      check("lcd_off_bank_kept", disp_bank, 0);
      lcd_en = 1'b1;
      tick();
      pix(2'd0); pix(2'd0); pix(2'd0); pix(2'd0);
      tick();
      check("restart_addr", wr_addr[wr_addr.size()-1], 14'd5760);

      // Mid-line reset returns disp_bank to 1 immediately
      fb.fb_ready = 1'b0;
      pix(2'd1); pix(2'd1); pix(2'd1); pix(2'd1); pix(2'd1); pix(2'd1);
      #3 rst = 1'b0;
      #1;
      check("midline_rst_we", fb.fb_we, 0);
      check("midline_rst_bank", disp_bank, 1);
      check("midline_rst_fd", frame_done, 0);
      tick();
      rst = 1'b1;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
